// File: rtl/fpga_3x3.sv
// fpga_3x3: 3x3 LUT4 fabric with 12 wired-OR tracks, per-pin source select, 5 configurable outputs
module fpga_3x3 (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   in1,
  input  logic [3:0]   in2,
  input  logic [3:0]   in3,
  input  logic [3:0]   in4,
  output logic [4:0]   out,
  input  logic [19:0]  iostream,
  input  logic [299:0] cbstream1,
  input  logic [119:0] cbstreamleft_or_right,
  input  logic [239:0] sbstream,
  input  logic [8:0]   clb_mux_sel,
  input  logic [143:0] bitstream
);
  logic [8:0] ff_q, ff_d;
  logic [359:0] pin_cfg;
  assign pin_cfg = {sbstream, cbstreamleft_or_right};
  function automatic logic [13:0] fabric(input logic [8:0] regs);
    logic [8:0] clb, lut;
    logic [31:0] pool;
    logic [15:0] trk, l;
    logic [35:0] pin;
    logic [9:0] f;
    logic [3:0] s;
    logic [4:0] o;
    clb = regs & clb_mux_sel;
    lut = '0;
    pool = '0;
    trk = '0;
    pin = '0;
    l = '0;
    f = '0;
    s = '0;
    o = '0;
    for (int n = 0; n < 11; n++) begin
      pool = {7'd0, clb, in4, in3, in2, in1};
      for (int k = 0; k < 12; k++) trk[k] = |(cbstream1[25*k +: 25] & pool[24:0]);
      for (int q = 0; q < 36; q++) begin
        f = pin_cfg[10*q +: 10];
        pin[q] = f[9] ^ (f[8] ? pool[f[4:0]] : trk[f[3:0]]);
      end
      for (int k = 0; k < 9; k++) begin
        l = bitstream[16*k +: 16];
        lut[k] = l[pin[4*k +: 4]];
        clb[k] = clb_mux_sel[k] ? regs[k] : lut[k];
      end
    end
    for (int j = 0; j < 5; j++) begin
      s = iostream[4*j +: 4];
      o[j] = trk[s] | (s == 4'd13);
    end
    return {o, lut};
  endfunction
  always_comb {out, ff_d} = fabric(ff_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) ff_q <= '0;
    else ff_q <= ff_d;
endmodule

// File: tb/tb_fpga_3x3.sv
// tb_fpga_3x3: directed vector table, multi-cycle sequences and randomized reference-model checks
module tb_fpga_3x3;
  logic         clk, reset;
  logic [3:0]   in1, in2, in3, in4;
  logic [4:0]   out;
  logic [19:0]  io;
  logic [299:0] cb;
  logic [119:0] cbl;
  logic [239:0] sb;
  logic [8:0]   sel;
  logic [143:0] bs;
  int checks = 0;
  int errors = 0;

  fpga_3x3 dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out(out),
    .iostream(io), .cbstream1(cb), .cbstreamleft_or_right(cbl), .sbstream(sb),
    .clb_mux_sel(sel), .bitstream(bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   i1;
    logic [3:0]   i2;
    logic [19:0]  io;
    logic [299:0] cb;
    logic [4:0]   exp;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    cb = '0; cbl = '0; sb = '0; bs = '0; io = '0; sel = '0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
  endtask

  task automatic set_f(input int q, input logic [9:0] v);
    if (q < 12) cbl[10*q +: 10] = v;
    else sb[10*(q-12) +: 10] = v;
  endtask

  function automatic logic [9:0] fld(input int q);
    if (q < 12) return cbl[10*q +: 10];
    return sb[10*(q-12) +: 10];
  endfunction

  function automatic logic [11:0] tracks(input logic [24:0] p);
    logic [11:0] t = '0;
    for (int k = 0; k < 12; k++)
      for (int i = 0; i < 25; i++)
        if (cb[25*k+i] && p[i]) t[k] = 1'b1;
    return t;
  endfunction

  function automatic logic pinv(input int q, input logic [24:0] p, input logic [11:0] t);
    logic [9:0] f;
    int idx;
    logic v;
    f = fld(q);
    if (f[8]) begin
      idx = int'(f[4:0]);
      v = (idx < 25) ? p[idx] : 1'b0;
    end else begin
      idx = int'(f[3:0]);
      v = (idx < 12) ? t[idx] : 1'b0;
    end
    return f[9] ? ~v : v;
  endfunction

  function automatic logic lut_at(input int k, input logic [24:0] p, input logic [11:0] t);
    int idx;
    idx = 0;
    for (int j = 0; j < 4; j++) if (pinv(4*k+j, p, t)) idx += (1 << j);
    return bs[16*k + idx];
  endfunction

  // Random configs only let a combinational CLB see other combinational CLBs of lower index,
  // so resolving them in index order gives the settled fabric values.
  function automatic logic [4:0] model(input logic [8:0] ff, output logic [8:0] lv);
    logic [8:0] c;
    logic [24:0] p;
    logic [11:0] t;
    logic [4:0] o;
    int s;
    c = '0;
    for (int k = 0; k < 9; k++) if (sel[k]) c[k] = ff[k];
    for (int k = 0; k < 9; k++)
      if (!sel[k]) begin
        p = {c, in4, in3, in2, in1};
        t = tracks(p);
        c[k] = lut_at(k, p, t);
      end
    p = {c, in4, in3, in2, in1};
    t = tracks(p);
    for (int k = 0; k < 9; k++) lv[k] = lut_at(k, p, t);
    for (int j = 0; j < 5; j++) begin
      s = int'(io[4*j +: 4]);
      o[j] = (s < 12) ? t[s] : (s == 13);
    end
    return o;
  endfunction

  task automatic rand_cfg();
    logic [9:0] f;
    int k;
    sel = 9'($urandom);
    for (int t = 0; t < 12; t++)
      for (int i = 0; i < 25; i++) begin
        cb[25*t+i] = ($urandom_range(0, 5) == 0);
        if (i >= 16 && t < 10) if (!sel[i-16]) cb[25*t+i] = 1'b0;
      end
    for (int q = 0; q < 36; q++) begin
      f = 10'($urandom);
      k = q / 4;
      if (!sel[k]) begin
        if (f[8]) begin
          if (f[4:0] >= 5'd16 && f[4:0] < 5'd25)
            if (!sel[int'(f[4:0]) - 16] && int'(f[4:0]) - 16 >= k) f[4] = 1'b0;
        end else if (f[3:0] == 4'd10 || f[3:0] == 4'd11) f[3:0] = 4'hC;
      end
      set_f(q, f);
    end
    bs = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
    io = 20'($urandom);
  endtask

  initial begin
    logic [299:0] cb_a, cb_or, cb_11;
    logic [8:0] ff_m, lv;
    logic [4:0] exp;
    reset = 1'b0;
    clr();
    cb_a = '0; cb_a[0] = 1'b1;
    cb_or = '0; cb_or[0] = 1'b1; cb_or[4] = 1'b1;
    cb_11 = '0; cb_11[25*11+5] = 1'b1;
    tbl[0]  = '{"reset_default", 4'b0011, 4'b0000, 20'h00000, 300'd0, 5'b00000};
    tbl[1]  = '{"pass_0011",     4'b0011, 4'b0000, 20'h00000, cb_a,   5'b11111};
    tbl[2]  = '{"pass_0010",     4'b0010, 4'b0000, 20'h00000, cb_a,   5'b00000};
    tbl[3]  = '{"const_in_hi",   4'b1111, 4'b1111, 20'hDCDCD, cb_a,   5'b10101};
    tbl[4]  = '{"const_in_lo",   4'b0000, 4'b0000, 20'hDCDCD, cb_a,   5'b10101};
    tbl[5]  = '{"wor_00",        4'b0000, 4'b0000, 20'h00000, cb_or,  5'b00000};
    tbl[6]  = '{"wor_01",        4'b0001, 4'b0000, 20'h00000, cb_or,  5'b11111};
    tbl[7]  = '{"wor_10",        4'b0000, 4'b0001, 20'h00000, cb_or,  5'b11111};
    tbl[8]  = '{"wor_11",        4'b0001, 4'b0001, 20'h00000, cb_or,  5'b11111};
    tbl[9]  = '{"track11",       4'b0000, 4'b0010, 20'hBBBBB, cb_11,  5'b11111};
    tbl[10] = '{"sel_14_15",     4'b1111, 4'b0000, 20'hEFEFE, cb_a,   5'b00000};
    for (int i = 0; i < 11; i++) begin
      in1 = tbl[i].i1; in2 = tbl[i].i2; io = tbl[i].io; cb = tbl[i].cb;
      #1;
      chk(tbl[i].name, out, tbl[i].exp);
    end

    clr();
    in1 = 4'b0011;
    #1 chk("reset_low_zero_cfg", out, 5'b00000);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_release", out, 5'b00000);
    end

    clr();
    for (int q = 0; q < 36; q++) set_f(q, 10'h00C);
    for (int k = 0; k < 9; k++) bs[16*k +: 16] = 16'hAAAA;
    set_f(0, 10'h300);
    for (int k = 1; k < 9; k++) set_f(4*k, 10'h300 | 10'(16 + k - 1));
    cb[24] = 1'b1;
    #1 chk("chain9_in0", out, 5'b11111);
    in1 = 4'b0001;
    #1 chk("chain9_in1", out, 5'b00000);

    clr();
    bs[15:0] = 16'h8000;
    for (int q = 0; q < 4; q++) set_f(q, 10'h100 | 10'(q));
    cb[25+16] = 1'b1;
    io = 20'h00001;
    in1 = 4'b1111;
    #1 chk("and4_1111", out, 5'b00001);
    in1 = 4'b1110;
    #1 chk("and4_1110", out, 5'b00000);
    in1 = 4'b0111;
    #1 chk("and4_0111", out, 5'b00000);

    bs[15:0] = 16'hAAAA;
    set_f(0, 10'h300);
    sel = 9'h001;
    in1 = 4'b0001;
    @(posedge clk); #1;
    chk("reg_load0", out, 5'b00000);
    in1 = 4'b0000;
    #2 chk("reg_before_edge", out, 5'b00000);
    @(posedge clk); #1;
    chk("reg_after_edge", out, 5'b00001);
    #2 reset = 1'b0;
    #1 chk("reg_async_clear", out, 5'b00000);
    @(posedge clk); #1;
    chk("reg_held_in_reset", out, 5'b00000);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reg_first_capture", out, 5'b00001);

    ff_m = '0;
    for (int n = 0; n < 300; n++) begin
      if (n % 10 == 0) begin
        rand_cfg();
        reset = 1'b0;
        #1 reset = 1'b1;
        ff_m = '0;
      end
      in1 = 4'($urandom); in2 = 4'($urandom); in3 = 4'($urandom); in4 = 4'($urandom);
      @(negedge clk);
      exp = model(ff_m, lv);
      chk($sformatf("rand_%0d", n), out, exp);
      @(posedge clk);
      ff_m = lv;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
